// File: rtl/serial_adder_8_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t        : FSM encoding (IDLE=0, RUN=1)
//   DEFAULT_WIDTH  : default operand width
//   result_w()     : width of the result bus for a given operand width
package serial_adder_8_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The result bus is twice the operand width so it lines up with the
  // serial subtractor's result format; the upper half is always zero.
  function automatic int result_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/serial_adder_8_if.sv
// Handshake/operand bus for the bit-serial adder.
//   start, add_x, add_y, carry_in : request side (master drives)
//   busy, done, sum, carry_out    : response side (slave drives)
// Modports: master (requester / testbench), slave (adder).
interface serial_adder_8_if
  import serial_adder_8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                         start;
  logic [WIDTH-1:0]             add_x;
  logic [WIDTH-1:0]             add_y;
  logic                         carry_in;
  logic                         busy;
  logic                         done;
  logic [result_w(WIDTH)-1:0]   sum;
  logic                         carry_out;

  modport master (
    output start, add_x, add_y, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, add_x, add_y, carry_in,
    output busy, done, sum, carry_out
  );

endinterface

// File: rtl/serial_adder_8_full_adder.sv
// Single-bit full adder cell used by the serial datapath.
//   x, y, carry_in : addend bits and incoming carry
//   sum            : x ^ y ^ carry_in
//   carry_out      : majority(x, y, carry_in)
module full_adder (
  output logic sum,
  output logic carry_out,
  input  logic x,
  input  logic y,
  input  logic carry_in
);

  assign sum       = x ^ y ^ carry_in;
  assign carry_out = (x & y) | (x & carry_in) | (y & carry_in);

endmodule

// File: rtl/serial_adder_8.sv
// Bit-serial ripple adder: X + Y + carry_in, one bit per clock, LSB first,
// through one full-adder cell and a carry flop.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_adder_8_if.slave
//            start/add_x/add_y/carry_in in, busy/done/sum/carry_out out
// A start seen in IDLE latches the operands; WIDTH edges later done pulses
// for one cycle with sum/carry_out updated. All outputs are registered.
module serial_adder_8
  import serial_adder_8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_8_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int RES_W = result_w(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               c_q, c_d;
  // Holds the WIDTH-1 most recent sum bits; the bit produced in the
  // current cycle is concatenated on top to form the full result.
  logic [WIDTH-2:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  logic               fa_sum;
  logic               fa_cout;
  logic [WIDTH-1:0]   res_full;

  full_adder u_fa (
    .sum       (fa_sum),
    .carry_out (fa_cout),
    .x         (x_q[0]),
    .y         (y_q[0]),
    .carry_in  (c_q)
  );

  // Result register after this cycle's shift, including the new bit.
  assign res_full = {fa_sum, res_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.add_x;
          y_d     = bus.add_y;
          c_d     = bus.carry_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        x_d   = {1'b0, x_q[WIDTH-1:1]};
        y_d   = {1'b0, y_q[WIDTH-1:1]};
        c_d   = fa_cout;
        res_d = res_full[WIDTH-1:1];
        cnt_d = cnt_q + CNT_W'(1);
        // This edge produces the last bit: publish the whole result at
        // once so sum never exposes a partially shifted value.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {{WIDTH{1'b0}}, res_full};
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule

// File: doc/serial_adder_8.md
Name: serial_adder_8

Overview:
- Bit-serial ripple adder: the addition counterpart to the 8-bit ripple borrow subtractor in the arithmetic library.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake.
- Result format matches the subtractor's: sum on a 2*WIDTH-bit bus, upper half zero, separate carry-out.

Parameters:
- WIDTH, 8, operand width in bits; number of serial add cycles (legal: 2..32).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only while idle.
- add_x  input  WIDTH  operand X; captured on the accepted start edge.
- add_y  input  WIDTH  operand Y; captured on the accepted start edge.
- carry_in  input  1  carry into bit 0; captured on the accepted start edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum and carry_out are valid and updated.
- sum  output  2*WIDTH  result; [WIDTH-1:0] = X+Y+carry_in mod 2^WIDTH, [2*WIDTH-1:WIDTH] = 0.
- carry_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: rst_n low forces, asynchronously:
  - state=IDLE; busy=0, done=0, sum=0, carry_out=0.
  - internal shift registers, carry flop and bit counter = 0.
- Reset mid-operation aborts the operation. No done is issued. The first start after rst_n rises is accepted normally.
- FSM states: IDLE, RUN.
- IDLE:
  - done=0 except during the completion cycle.
  - On an edge with start=1: latch add_x, add_y, carry_in; clear count; busy=1; go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - s = x[0]^y[0]^c; c <= majority(x[0],y[0],c).
  - Shift x and y right by one; shift s into the MSB of the result shift register; count++.
  - On the edge where count reaches WIDTH:
    - sum[WIDTH-1:0] <= result (including the final bit); sum[2*WIDTH-1:WIDTH] <= 0.
    - carry_out <= final carry; done <= 1; busy <= 0; go to IDLE.
- Latency: start accepted at edge k → done high and results valid after edge k+WIDTH. WIDTH=8 gives 8 cycles. Throughput: one add per WIDTH+1 cycles minimum.
- done is a single-cycle pulse and deasserts on the next edge.
- sum and carry_out hold their values until the next completion. They never show partial results.
- start while busy=1: ignored. Operands are not re-latched and no queueing occurs.
- start high in the done cycle: accepted, since the FSM is in IDLE. The new operation begins; the previous sum stays valid until the new completion.
- add_x, add_y and carry_in may change freely after the accept edge.
- Overflow wraps modulo 2^WIDTH, with the carry reported on carry_out only.
- Bit counter width is clog2(WIDTH+1).
- No combinational path from inputs to outputs.

Decomposition:
- Shared arithmetic package/header:
  - state encodings IDLE=1'b0, RUN=1'b1.
  - default WIDTH localparam.
  - result-bus width rule (2*WIDTH).
- One sub-module: full_adder (sum, carry_out, x, y, carry_in). This is the adder twin of the existing full subtractor cell and is instantiated once in the serial datapath.
- Counter, shift registers and FSM are inline.

Test Plan:
- add_x=0x25, add_y=0x13, carry_in=0, start 1 cycle → busy for 8 cycles, then done pulse; sum=0x0038, carry_out=0.
- add_x=0xFF, add_y=0x01, carry_in=0 → sum=0x0000, carry_out=1. Then 0xFF+0xFF, carry_in=1 → sum=0x00FF, carry_out=1.
- Start 0x10+0x20; assert start with 0x7F+0x7F at cycle 3 → second request ignored; done after 8 cycles with sum=0x0030; no second done pulse.
- Start 0x0F+0x01; pulse rst_n low at cycle 4 → busy/done/sum/carry_out immediately 0, no done; then 0x0F+0x01 completes to sum=0x0010.
- Back-to-back: 0x01+0x02, with start held high on its done cycle for 0x80+0x80 → first done sum=0x0003; sum holds 0x0003 for 8 cycles; second done sum=0x0000, carry_out=1.
- Randomized 1000 operands against a reference X+Y+cin model → sum and carry_out match on every done; each done lands exactly 8 cycles after its accept.
